alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined ALU for the board-level lab datapath. Operands and opcode are loaded into internal registers from a shared input bus. A start pulse then issues the operation into a two-stage pipeline, which accepts one operation per cycle. Results come back with a one-cycle valid strobe, status flags (zero, carry/borrow, signed overflow) and an illegal-opcode error flag. The block is the successor to the 6-bit single-cycle ALU and drives the LED/result bank.

## Interface
- N_BITS, 8, operand/result width (≥ 2)
- OP_BITS, 6, opcode width (fixed encoding below; must be 6)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset == 0 resets on the clock edge)
- i_data  in  N_BITS  shared load bus; low OP_BITS bits used for opcode
- i_load_a  in  1  capture i_data into A register
- i_load_b  in  1  capture i_data into B register
- i_load_op  in  1  capture i_data[OP_BITS-1:0] into OP register
- i_start  in  1  issue one operation using current A/B/OP registers
- o_result  out  N_BITS  registered result, held until next valid
- o_valid  out  1  one-cycle strobe, o_result/flags updated this cycle
- o_zero  out  1  o_result == 0
- o_carry  out  1  ADD carry-out; SUB borrow (A < B unsigned); else 0
- o_overflow  out  1  signed overflow for ADD/SUB; else 0
- o_err  out  1  issued opcode was illegal
- o_busy  out  1  at least one operation in flight (stage 1 or 2 occupied)

## Operation
- Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010 (logical right), SRA 000011 (arithmetic right, sign-filled).
- Arithmetic is modulo 2^N_BITS. SUB computed as A + ~B + 1. Overflow = operand signs agree (ADD) / differ (SUB) and result sign differs from A.
- Shifts: amount = B taken as unsigned. If B ≥ N_BITS: SRL → 0, SRA → all bits = A[N_BITS-1].
- Illegal opcode: result 0, o_zero 1, o_carry/o_overflow 0, o_err 1. The operation still produces an o_valid.
- Load strobes are independent and may be asserted together (all targets take i_data). Loads are accepted in any cycle, including while busy.
- i_start snapshots A, B and OP into stage 1. A load in the same cycle as i_start is NOT seen by that operation; the pre-edge register value is used.
- Stage 1 computes the raw result and flags. Stage 2 registers them onto the outputs.
- Pipeline has no back-pressure. Every i_start produces exactly one o_valid, in issue order.
- Outputs hold their last value between valids. o_err is updated only with o_valid.

## Timing
- Reset (reset == 0 at an edge): A, B, OP, both pipeline stages and all outputs go to 0.
- Reset mid-operation: in-flight operations are discarded. No o_valid is produced for them.
- i_start sampled high at edge k → o_valid high for the cycle after edge k+1. Latency is 2 cycles.
- o_result and flags change only at the edge that raises o_valid.
- Throughput: 1 operation/cycle. i_start held high for n cycles → n consecutive o_valid cycles, 2 cycles later.
- o_busy is high whenever stage 1 or stage 2 holds a valid operation. It is combinational from the stage valid bits.
- i_start during reset is ignored.

## Test plan
- N_BITS=8: load A=0x7F, B=0x01, OP=ADD, start → two cycles later o_valid, o_result=0x80, o_overflow=1, o_carry=0, o_zero=0.
- Load A=0x05, B=0x07, OP=SUB, start → 0xFE, o_carry=1, o_overflow=0. Then A=B=0x33 SUB → 0x00, o_zero=1.
- A=0x90, B=3: SRA → 0xF2, SRL → 0x12. B=9: SRA → 0xFF, SRL → 0x00.
- Back-to-back starts on three consecutive cycles (AND, OR, NOR with A=0xF0, B=0x3C, reloading OP between issues) → three consecutive valids: 0x30, 0xFC, 0x03.
- A=0x10, B=0x01, OP=ADD; assert i_load_a with i_data=0x20 and i_start in the same cycle → result 0x11. The next start gives 0x21.
- OP=0x3F, start → o_result=0, o_err=1. Issue an ADD and pull reset low one cycle later → no o_valid, all outputs 0.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: operand/opcode registers loaded from a shared bus, stage 1 holds the
// computed result and flags, stage 2 is the registered output bank with a one-cycle valid strobe.
module alu_pipe #(
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned OP_BITS = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_data,
  input  logic              i_load_a,
  input  logic              i_load_b,
  input  logic              i_load_op,
  input  logic              i_start,
  output logic [N_BITS-1:0] o_result,
  output logic              o_valid,
  output logic              o_zero,
  output logic              o_carry,
  output logic              o_overflow,
  output logic              o_err,
  output logic              o_busy
);

  localparam logic [OP_BITS-1:0] OpAdd = OP_BITS'(6'b100000);
  localparam logic [OP_BITS-1:0] OpSub = OP_BITS'(6'b100010);
  localparam logic [OP_BITS-1:0] OpAnd = OP_BITS'(6'b100100);
  localparam logic [OP_BITS-1:0] OpOr  = OP_BITS'(6'b100101);
  localparam logic [OP_BITS-1:0] OpXor = OP_BITS'(6'b100110);
  localparam logic [OP_BITS-1:0] OpNor = OP_BITS'(6'b100111);
  localparam logic [OP_BITS-1:0] OpSrl = OP_BITS'(6'b000010);
  localparam logic [OP_BITS-1:0] OpSra = OP_BITS'(6'b000011);

  localparam int unsigned OpW = (N_BITS < OP_BITS) ? N_BITS : OP_BITS;
  localparam logic [N_BITS-1:0] NBitsVal = N_BITS'(N_BITS);
  localparam int unsigned Msb = N_BITS - 1;

  logic [N_BITS-1:0]  a_q, a_d, b_q, b_d;
  logic [OP_BITS-1:0] op_q, op_d;

  logic              s1_valid_q, s1_valid_d;
  logic [N_BITS-1:0] s1_result_q, s1_result_d;
  logic              s1_zero_q, s1_zero_d;
  logic              s1_carry_q, s1_carry_d;
  logic              s1_ovf_q, s1_ovf_d;
  logic              s1_err_q, s1_err_d;

  logic              out_valid_q, out_valid_d;
  logic [N_BITS-1:0] out_result_q, out_result_d;
  logic              out_zero_q, out_zero_d;
  logic              out_carry_q, out_carry_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_err_q, out_err_d;

  logic [N_BITS:0]   sum_ext;
  logic [N_BITS-1:0] alu_res;
  logic              alu_carry, alu_ovf, alu_err, shift_big;

  // Operand registers; loads are independent of the pipeline and may coincide with i_start.
  always_comb begin
    a_d  = i_load_a ? i_data : a_q;
    b_d  = i_load_b ? i_data : b_q;
    op_d = op_q;
    if (i_load_op) op_d = OP_BITS'(i_data[OpW-1:0]);
  end

  always_comb begin
    sum_ext   = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    shift_big = (b_q >= NBitsVal);
    unique case (op_q)
      OpAdd: begin
        sum_ext   = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = sum_ext[N_BITS-1:0];
        alu_carry = sum_ext[N_BITS];
        alu_ovf   = (a_q[Msb] == b_q[Msb]) && (alu_res[Msb] != a_q[Msb]);
      end
      OpSub: begin
        sum_ext   = {1'b0, a_q} + {1'b0, ~b_q} + (N_BITS + 1)'(1);
        alu_res   = sum_ext[N_BITS-1:0];
        // No carry-out of A + ~B + 1 means A < B unsigned.
        alu_carry = ~sum_ext[N_BITS];
        alu_ovf   = (a_q[Msb] != b_q[Msb]) && (alu_res[Msb] != a_q[Msb]);
      end
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpXor: alu_res = a_q ^ b_q;
      OpNor: alu_res = ~(a_q | b_q);
      OpSrl: alu_res = shift_big ? '0 : (a_q >> b_q);
      OpSra: alu_res = shift_big ? {N_BITS{a_q[Msb]}} : $unsigned($signed(a_q) >>> b_q);
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d  = i_start;
    s1_result_d = s1_result_q;
    s1_zero_d   = s1_zero_q;
    s1_carry_d  = s1_carry_q;
    s1_ovf_d    = s1_ovf_q;
    s1_err_d    = s1_err_q;
    if (i_start) begin
      s1_result_d = alu_res;
      s1_zero_d   = (alu_res == '0);
      s1_carry_d  = alu_carry;
      s1_ovf_d    = alu_ovf;
      s1_err_d    = alu_err;
    end
  end

  // Output bank changes only on the edge that raises o_valid.
  always_comb begin
    out_valid_d  = s1_valid_q;
    out_result_d = out_result_q;
    out_zero_d   = out_zero_q;
    out_carry_d  = out_carry_q;
    out_ovf_d    = out_ovf_q;
    out_err_d    = out_err_q;
    if (s1_valid_q) begin
      out_result_d = s1_result_q;
      out_zero_d   = s1_zero_q;
      out_carry_d  = s1_carry_q;
      out_ovf_d    = s1_ovf_q;
      out_err_d    = s1_err_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      s1_valid_q   <= 1'b0;
      s1_result_q  <= '0;
      s1_zero_q    <= 1'b0;
      s1_carry_q   <= 1'b0;
      s1_ovf_q     <= 1'b0;
      s1_err_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_carry_q  <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      s1_valid_q   <= s1_valid_d;
      s1_result_q  <= s1_result_d;
      s1_zero_q    <= s1_zero_d;
      s1_carry_q   <= s1_carry_d;
      s1_ovf_q     <= s1_ovf_d;
      s1_err_q     <= s1_err_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_zero_q   <= out_zero_d;
      out_carry_q  <= out_carry_d;
      out_ovf_q    <= out_ovf_d;
      out_err_q    <= out_err_d;
    end
  end

  assign o_result   = out_result_q;
  assign o_valid    = out_valid_q;
  assign o_zero     = out_zero_q;
  assign o_carry    = out_carry_q;
  assign o_overflow = out_ovf_q;
  assign o_err      = out_err_q;
  assign o_busy     = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push hand-computed expectations, a negedge
// monitor pops and compares them whenever o_valid is seen.
module tb_alu_pipe;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] i_data;
  logic       i_load_a, i_load_b, i_load_op, i_start;
  logic [7:0] o_result;
  logic       o_valid, o_zero, o_carry, o_overflow, o_err, o_busy;

  alu_pipe #(.N_BITS(8), .OP_BITS(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .i_data     (i_data),
    .i_load_a   (i_load_a),
    .i_load_b   (i_load_b),
    .i_load_op  (i_load_op),
    .i_start    (i_start),
    .o_result   (o_result),
    .o_valid    (o_valid),
    .o_zero     (o_zero),
    .o_carry    (o_carry),
    .o_overflow (o_overflow),
    .o_err      (o_err),
    .o_busy     (o_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] res;
    logic       z, c, v, e;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [7:0] ADD = 8'h20, SUB = 8'h22, AND = 8'h24, OR = 8'h25;
  localparam logic [7:0] NOR = 8'h27, SRL = 8'h02, SRA = 8'h03;
  localparam logic [2:0] LA = 3'b001, LB = 3'b010, LO = 3'b100, LN = 3'b000;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic z, c, v, e);
    exp_t x;
    x.res = r; x.z = z; x.c = c; x.v = v; x.e = e; x.cyc = 0;
    return x;
  endfunction

  // Drive one cycle from a negedge: optional start (pushing e), loads of d, then wait a cycle.
  task automatic step(input logic st, input logic [2:0] ld, input logic [7:0] d, input exp_t e);
    exp_t x;
    i_data    = d;
    i_load_a  = ld[0];
    i_load_b  = ld[1];
    i_load_op = ld[2];
    i_start   = st;
    if (st) begin
      x = e;
      x.cyc = cyc + 2;
      q.push_back(x);
    end
    @(negedge clock);
    i_load_a = 0; i_load_b = 0; i_load_op = 0; i_start = 0;
  endtask

  task automatic ld(input logic [2:0] sel, input logic [7:0] d);
    step(1'b0, sel, d, mk(0, 0, 0, 0, 0));
  endtask

  task automatic go(input exp_t e);
    step(1'b1, LN, 8'h00, e);
  endtask

  always @(negedge clock) begin
    exp_t x;
    if (o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        x = q.pop_front();
        chk("latency", cyc, x.cyc);
        chk("result", o_result, x.res);
        chk("zero", o_zero, x.z);
        chk("carry", o_carry, x.c);
        chk("overflow", o_overflow, x.v);
        chk("err", o_err, x.e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected to finish");
    $fatal(1);
  end

  initial begin
    reset = 0; i_data = 0; i_load_a = 0; i_load_b = 0; i_load_op = 0; i_start = 0;
    repeat (3) @(negedge clock);
    chk("rst_result", o_result, 0);
    chk("rst_flags", {o_valid, o_zero, o_carry, o_overflow, o_err, o_busy}, 0);
    reset = 1;

    // ADD signed overflow
    ld(LA, 8'h7F); ld(LB, 8'h01); ld(LO, ADD);
    go(mk(8'h80, 0, 0, 1, 0));
    chk("busy_in_flight", o_busy, 1);
    repeat (3) @(negedge clock);
    chk("hold_result", o_result, 8'h80);
    chk("hold_novalid", o_valid, 0);
    chk("idle_busy", o_busy, 0);

    // SUB with borrow, then zero result
    ld(LA, 8'h05); ld(LB, 8'h07); ld(LO, SUB);
    go(mk(8'hFE, 0, 1, 0, 0));
    ld(LA | LB, 8'h33);
    go(mk(8'h00, 1, 0, 0, 0));

    // Shifts, in range and saturating
    ld(LA, 8'h90); ld(LB, 8'h03); ld(LO, SRA);
    go(mk(8'hF2, 0, 0, 0, 0));
    ld(LO, SRL);
    go(mk(8'h12, 0, 0, 0, 0));
    ld(LB, 8'h09);
    go(mk(8'h00, 1, 0, 0, 0));
    ld(LO, SRA);
    go(mk(8'hFF, 0, 0, 0, 0));

    // Back-to-back issue, OP reloaded alongside each start
    ld(LA, 8'hF0); ld(LB, 8'h3C); ld(LO, AND);
    step(1'b1, LO, OR, mk(8'h30, 0, 0, 0, 0));
    step(1'b1, LO, NOR, mk(8'hFC, 0, 0, 0, 0));
    go(mk(8'h03, 0, 0, 0, 0));

    // Load coincident with start is not seen by that operation
    ld(LA, 8'h10); ld(LB, 8'h01); ld(LO, ADD);
    step(1'b1, LA, 8'h20, mk(8'h11, 0, 0, 0, 0));
    go(mk(8'h21, 0, 0, 0, 0));

    // Illegal opcode
    ld(LO, 8'h3F);
    go(mk(8'h00, 1, 0, 0, 1));
    repeat (4) @(negedge clock);
    chk("drain", q.size(), 0);

    // Reset one cycle after issue discards the operation (nothing pushed)
    ld(LO, ADD);
    i_start = 1;
    @(negedge clock);
    i_start = 0;
    reset = 0;
    @(negedge clock);
    reset = 1;
    repeat (4) @(negedge clock);
    chk("midrst_result", o_result, 0);
    chk("midrst_flags", {o_valid, o_zero, o_carry, o_overflow, o_err, o_busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
